// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial, LSB-first subtractor computing diff = b - a over
//               WIDTH bits with a single full-subtractor cell reused for
//               WIDTH cycles. Start/busy/done handshake, unsigned borrow and
//               signed overflow flags.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               start      - request, sampled only in IDLE
//               a          - subtrahend, sampled on accepted start
//               b          - minuend, sampled on accepted start
//               busy       - high while bits are being processed
//               done       - one-cycle pulse, results valid from this cycle
//               diff       - b - a modulo 2^WIDTH
//               borrow_out - final borrow, 1 iff b < a (unsigned)
//               ovf        - signed overflow of b - a
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             msb_a;
    logic             msb_b;
    logic             d;
    logic             br_next;
    logic             last_bit;

    // Full-subtractor cell operating on the current LSBs.
    always_comb begin
        d        = b_sh[0] ^ a_sh[0] ^ br;
        br_next  = (~b_sh[0] & a_sh[0]) | (~(b_sh[0] ^ a_sh[0]) & br);
        last_bit = (cnt == LAST_BIT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start)    state_next = S_SHIFT;
            S_SHIFT: if (last_bit) state_next = S_DONE;
            S_DONE:                state_next = S_IDLE;
            default:               state_next = S_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state == S_SHIFT);
        done = (state == S_DONE);
    end

    // Datapath: operand capture, bit-serial shifting and result commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            msb_a      <= 1'b0;
            msb_b      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        r_sh  <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        msb_a <= a[WIDTH-1];
                        msb_b <= b[WIDTH-1];
                    end
                end
                S_SHIFT: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    r_sh <= {d, r_sh[WIDTH-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        // The final d is the result sign bit; overflow occurs
                        // when operand signs differ and the result sign does
                        // not follow the minuend.
                        diff       <= {d, r_sh[WIDTH-1:1]};
                        borrow_out <= br_next;
                        ovf        <= (msb_a != msb_b) && (d != msb_b);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing diff = b - a over WIDTH bits.
- Reuses one full-subtractor cell for WIDTH cycles, in place of a WIDTH-bit ripple array.
- Start/busy/done handshake. Unsigned borrow and signed overflow flags.
- Sits alongside the combinational adder cells as the area-cheap subtract path for datapath blocks.

Parameters:
WIDTH, 8, operand/result width in bits (legal range WIDTH >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  subtrahend; sampled on accepted start
b  input  WIDTH  minuend; sampled on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; diff/borrow_out/ovf valid from this cycle
diff  output  WIDTH  b - a modulo 2^WIDTH
borrow_out  output  1  final borrow; 1 iff b < a (unsigned)
ovf  output  1  signed overflow of b - a (two's complement)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, ovf=0. Internal shift registers, borrow and bit counter all 0.
- Reset mid-operation: abort immediately to the reset values above. No partial result is ever presented.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On the edge where start=1, load a_sh<=a, b_sh<=b, br<=0, cnt<=0, r_sh<=0.
  - Capture msb_a<=a[WIDTH-1] and msb_b<=b[WIDTH-1]. Go to SHIFT.
- SHIFT (one bit per clock):
  - d = b_sh[0] ^ a_sh[0] ^ br
  - br_next = (~b_sh[0] & a_sh[0]) | (~(b_sh[0] ^ a_sh[0]) & br)
  - Shift a_sh and b_sh right by one. Shift d into r_sh at the MSB (r_sh <= {d, r_sh[WIDTH-1:1]}). br <= br_next. cnt <= cnt+1.
  - On the edge processing cnt==WIDTH-1: diff <= final r_sh, borrow_out <= br_next.
  - Also on that edge: ovf <= (msb_a != msb_b) && (d != msb_b). Go to DONE.
- DONE: lasts exactly one cycle, then return to IDLE.
- Outputs: busy = (state==SHIFT). done = (state==DONE).
- Latency: start accepted on edge k.
  - busy high for exactly WIDTH cycles (after edge k through edge k+WIDTH).
  - done high for the one cycle after edge k+WIDTH.
  - Earliest next accepted start is edge k+WIDTH+2.
- Result hold: diff/borrow_out/ovf are updated only at completion. They hold their value through IDLE and the next operation until the next completion.
- start while SHIFT or DONE: ignored, no queuing.
- a/b changes after acceptance: no effect on the result.
- Arithmetic is modulo 2^WIDTH. No sign extension. Width of cnt is clog2(WIDTH).

Test Plan (WIDTH=8):
- b=0x05, a=0x03, start 1 cycle -> busy 8 cycles, done 1 cycle, diff=0x02, borrow_out=0, ovf=0.
- b=0x03, a=0x05 -> diff=0xFE, borrow_out=1, ovf=0; then b=0x00, a=0x01 -> diff=0xFF, borrow_out=1, ovf=0.
- Signed overflow: b=0x80, a=0x01 -> diff=0x7F, borrow_out=0, ovf=1; b=0x7F, a=0xFF -> diff=0x80, borrow_out=1, ovf=1.
- Equal operands b=a=0xFF -> diff=0x00, borrow_out=0, ovf=0; previous results held unchanged until this done.
- Start b=0x10, a=0x01; reassert start with b=0xAA, a=0x55 during busy and during done -> single done pulse, diff=0x0F; second request not executed.
- Assert rst_n=0 asynchronously during the 4th SHIFT cycle -> busy/done/diff/borrow_out/ovf go 0 before the next edge; next op b=0x20, a=0x08 -> diff=0x18.
